// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO pointer controller and FIFO_mem.
package fifo_pkg;

    localparam int FIFO_ADDR_W = 4;
    localparam int FIFO_DEPTH  = 16;
    localparam int FIFO_THRESH = 12;

    // Pointer carries one extra wrap bit above the memory address.
    typedef logic [FIFO_ADDR_W:0] fifo_ptr_t;

endpackage

// File: rtl/fifo_ptr_ctrl_if.sv
// Request/status bundle between the FIFO users and the pointer controller.
interface fifo_ptr_ctrl_if
    import fifo_pkg::*;
#(
    parameter int ADDR_W = FIFO_ADDR_W
);

    logic              wr_req;
    logic              rd_req;
    logic              err_clr;
    logic              wen;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] raddr;
    logic              rd_ack;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              threshold;
    logic              overflow;
    logic              underflow;

    // Producer/consumer side: issues requests, observes status.
    modport master (
        output wr_req, rd_req, err_clr,
        input  wen, waddr, raddr, rd_ack, count,
        input  full, empty, threshold, overflow, underflow
    );

    // Controller side.
    modport slave (
        input  wr_req, rd_req, err_clr,
        output wen, waddr, raddr, rd_ack, count,
        output full, empty, threshold, overflow, underflow
    );

endinterface

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer: ADDR_W+1 bits, async reset, increment enable.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int ADDR_W = FIFO_ADDR_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    output logic [ADDR_W:0] ptr
);

    localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);

    // Advance by one on each enabled edge; wraps naturally modulo 2**(ADDR_W+1).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + ONE;
        end
    end

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// Pointer and flag controller for a single-clock FIFO in front of FIFO_mem.
module fifo_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W = FIFO_ADDR_W,
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int THRESH = FIFO_THRESH
) (
    input  logic            wclk,
    input  logic            rst,
    fifo_ptr_ctrl_if.slave  bus
);

    localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] THRESH_C = (ADDR_W + 1)'(THRESH);

    logic [ADDR_W:0] wptr;
    logic [ADDR_W:0] rptr;
    logic [ADDR_W:0] cnt;
    logic            full_i;
    logic            empty_i;
    logic            wen_i;
    logic            ack_i;
    logic            ov_q;
    logic            un_q;

    fifo_ptr #(.ADDR_W(ADDR_W)) u_wptr (
        .clk (wclk),
        .rst (rst),
        .inc (wen_i),
        .ptr (wptr)
    );

    fifo_ptr #(.ADDR_W(ADDR_W)) u_rptr (
        .clk (wclk),
        .rst (rst),
        .inc (ack_i),
        .ptr (rptr)
    );

    // Occupancy and accept decisions, all from registered pointers.
    always_comb begin
        cnt     = wptr - rptr;
        full_i  = (cnt == DEPTH_C);
        empty_i = (cnt == '0);
        wen_i   = bus.wr_req & ~full_i & ~rst;
        ack_i   = bus.rd_req & ~empty_i & ~rst;
    end

    // Sticky error flags; a new error on the same edge beats err_clr.
    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            ov_q <= 1'b0;
            un_q <= 1'b0;
        end else begin
            if (bus.wr_req & full_i) begin
                ov_q <= 1'b1;
            end else if (bus.err_clr) begin
                ov_q <= 1'b0;
            end
            if (bus.rd_req & empty_i) begin
                un_q <= 1'b1;
            end else if (bus.err_clr) begin
                un_q <= 1'b0;
            end
        end
    end

    // Drive the interface outputs.
    always_comb begin
        bus.wen       = wen_i;
        bus.rd_ack    = ack_i;
        bus.waddr     = wptr[ADDR_W-1:0];
        bus.raddr     = rptr[ADDR_W-1:0];
        bus.count     = cnt;
        bus.full      = full_i;
        bus.empty     = empty_i;
        bus.threshold = (cnt >= THRESH_C);
        bus.overflow  = ov_q;
        bus.underflow = un_q;
    end

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Scoreboard bench for fifo_ptr_ctrl against a queue-based FIFO model.
module tb_fifo_ptr_ctrl;
    import fifo_pkg::*;

    typedef struct {
        logic       wen;
        logic       ack;
        logic [3:0] wa;
        logic [3:0] ra;
        logic [4:0] cnt;
        logic       full;
        logic       empty;
        logic       thr;
        logic       ov;
        logic       un;
        string      tag;
    } exp_t;

    logic wclk;
    logic rst;

    fifo_ptr_ctrl_if #(.ADDR_W(FIFO_ADDR_W)) bus ();

    fifo_ptr_ctrl #(
        .ADDR_W (FIFO_ADDR_W),
        .DEPTH  (FIFO_DEPTH),
        .THRESH (FIFO_THRESH)
    ) dut (
        .wclk (wclk),
        .rst  (rst),
        .bus  (bus)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    // Reference model: the FIFO as a queue of the slots it occupies.
    int          m_slots[$];
    int unsigned m_wr_tot = 0;
    int unsigned m_rd_tot = 0;
    bit          m_ov = 0;
    bit          m_un = 0;

    // One clock cycle: drive inputs between edges, push the expected view.
    task automatic cycle(input bit wr, input bit rd, input bit clr, input bit r, input string tag);
        exp_t e;
        bit   is_full;
        bit   is_empty;
        @(posedge wclk);
        #1;
        rst         = r;
        bus.wr_req  = wr;
        bus.rd_req  = rd;
        bus.err_clr = clr;
        if (r) begin
            m_slots.delete();
            m_wr_tot = 0;
            m_rd_tot = 0;
            m_ov     = 0;
            m_un     = 0;
        end
        is_full  = (m_slots.size() == FIFO_DEPTH);
        is_empty = (m_slots.size() == 0);
        e.wen   = wr && !is_full && !r;
        e.ack   = rd && !is_empty && !r;
        e.wa    = 4'(m_wr_tot % FIFO_DEPTH);
        e.ra    = is_empty ? 4'(m_rd_tot % FIFO_DEPTH) : 4'(m_slots[0]);
        e.cnt   = 5'(m_slots.size());
        e.full  = is_full;
        e.empty = is_empty;
        e.thr   = (m_slots.size() >= FIFO_THRESH);
        e.ov    = m_ov;
        e.un    = m_un;
        e.tag   = tag;
        sb.push_back(e);
        if (!r) begin
            if (wr && is_full) m_ov = 1;
            else if (clr)      m_ov = 0;
            if (rd && is_empty) m_un = 1;
            else if (clr)       m_un = 0;
            if (e.ack) begin
                void'(m_slots.pop_front());
                m_rd_tot++;
            end
            if (e.wen) begin
                m_slots.push_back(int'(m_wr_tot % FIFO_DEPTH));
                m_wr_tot++;
            end
        end
    endtask

    // Monitor: on each falling edge compare the DUT against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge wclk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_tests++;
                if (bus.wen !== e.wen || bus.rd_ack !== e.ack || bus.waddr !== e.wa ||
                    bus.raddr !== e.ra || bus.count !== e.cnt || bus.full !== e.full ||
                    bus.empty !== e.empty || bus.threshold !== e.thr ||
                    bus.overflow !== e.ov || bus.underflow !== e.un) begin
                    n_fail++;
                    $display("FAIL %s @%0t: got wen=%b ack=%b wa=%0d ra=%0d cnt=%0d f=%b e=%b thr=%b ov=%b un=%b; want wen=%b ack=%b wa=%0d ra=%0d cnt=%0d f=%b e=%b thr=%b ov=%b un=%b",
                             e.tag, $time, bus.wen, bus.rd_ack, bus.waddr, bus.raddr, bus.count,
                             bus.full, bus.empty, bus.threshold, bus.overflow, bus.underflow,
                             e.wen, e.ack, e.wa, e.ra, e.cnt, e.full, e.empty, e.thr, e.ov, e.un);
                end
            end
        end
    end

    initial begin
        int wp;
        int rp;
        rst         = 1'b1;
        bus.wr_req  = 1'b0;
        bus.rd_req  = 1'b0;
        bus.err_clr = 1'b0;

        repeat (5) cycle(0, 0, 0, 1, "reset");
        repeat (2) cycle(0, 0, 0, 0, "idle");

        repeat (16) cycle(1, 0, 0, 0, "fill");
        repeat (3)  cycle(1, 0, 0, 0, "overflow");
        cycle(0, 0, 1, 0, "ovclr");
        cycle(0, 0, 0, 0, "ovclr_idle");

        repeat (18) cycle(0, 1, 0, 0, "drain");
        cycle(0, 0, 1, 0, "unclr");

        repeat (5)  cycle(1, 0, 0, 0, "preload");
        repeat (40) cycle(1, 1, 0, 0, "both_wrap");
        repeat (11) cycle(1, 0, 0, 0, "refill");
        repeat (3)  cycle(1, 1, 0, 0, "both_full");
        cycle(1, 0, 1, 0, "clr_vs_ov");
        cycle(0, 0, 1, 0, "clr_after");
        cycle(0, 0, 0, 0, "clr_check");
        repeat (16) cycle(0, 1, 0, 0, "drain2");
        repeat (2)  cycle(1, 1, 0, 0, "both_empty");
        cycle(0, 0, 1, 0, "clr2");

        for (int i = 0; i < 300; i++) begin
            wp = (i < 150) ? 70 : 30;
            rp = (i < 150) ? 30 : 70;
            cycle(bit'($urandom_range(0, 99) < wp), bit'($urandom_range(0, 99) < rp),
                  bit'($urandom_range(0, 99) < 5), 0, "random");
        end

        cycle(0, 0, 0, 1, "rst2");
        repeat (9) cycle(1, 0, 0, 0, "load9");
        cycle(1, 0, 0, 1, "async_rst");
        repeat (2) cycle(0, 0, 0, 0, "post_rst");

        // Bounded drain of the scoreboard.
        repeat (3) @(negedge wclk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d entries left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_ptr_ctrl.md
Name: fifo_ptr_ctrl

Overview:
- Pointer and flag controller that sits directly upstream of the FIFO memory (FIFO_mem).
- Accepts producer write requests and consumer read requests.
- Generates the memory's waddr, raddr and wen, and owns the full, empty, threshold, overflow and underflow status.
- Together with FIFO_mem it forms a 16-entry single-clock FIFO.

Parameters:
- ADDR_W, 4, memory address width.
- DEPTH, 16, number of entries; must equal 2**ADDR_W.
- THRESH, 12, occupancy at or above which threshold asserts; legal range 1..DEPTH.

Ports:
- wclk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_req  in  1  producer requests a write this cycle.
- rd_req  in  1  consumer requests a read this cycle.
- err_clr  in  1  synchronous clear of the sticky overflow/underflow flags.
- wen  out  1  write enable to memory.
- waddr  out  ADDR_W  write address to memory.
- raddr  out  ADDR_W  read address to memory.
- rd_ack  out  1  read accepted this cycle; memory rdata at raddr is valid.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- threshold  out  1  count >= THRESH.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
- State: wptr and rptr, each ADDR_W+1 bits (extra wrap bit); overflow and underflow registers. Nothing else is stored.
- Reset (async, rst=1): wptr=rptr=0, overflow=underflow=0.
  - Outputs while reset is held: wen=0, rd_ack=0, waddr=raddr=0, count=0, empty=1, full=0, threshold=0.
  - Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.
- Accept rules (combinational, from current registered state):
  - wen = wr_req & ~full & ~rst.
  - rd_ack = rd_req & ~empty & ~rst.
- Addresses: waddr = wptr[ADDR_W-1:0]; raddr = rptr[ADDR_W-1:0].
  - The memory writes wdata at waddr on the same wclk edge where wen=1.
  - rdata at raddr is valid in the cycle rd_ack=1 (zero-latency read).
- Pointer update on rising edge:
  - wptr += 1 when wen.
  - rptr += 1 when rd_ack.
  - Both wrap modulo 2**(ADDR_W+1); low bits wrap 15 -> 0.
- count = wptr - rptr, modulo 2**(ADDR_W+1).
  - full, empty and threshold derive from count, so they are glitch-free functions of registers.
  - They reflect an update one cycle after the accepting edge.
- Simultaneous read and write:
  - Not full and not empty: both accepted, count unchanged.
  - Full: read accepted, write rejected (full is judged on pre-edge state); overflow sets.
  - Empty: write accepted, read rejected; underflow sets.
- overflow: set on an edge where wr_req & full.
- underflow: set on an edge where rd_req & empty.
- Both flags hold until rst, or until an edge where err_clr=1. If err_clr and a new error coincide, the set wins.
- A rejected request never moves a pointer and never corrupts contents.

Decomposition:
- Shared package fifo_pkg holds:
  - Constants FIFO_ADDR_W=4, FIFO_DEPTH=16, FIFO_THRESH=12, used as parameter defaults by both fifo_ptr_ctrl and FIFO_mem.
  - Typedef for the ADDR_W+1-bit pointer type.
- One sub-module, fifo_ptr: an ADDR_W+1-bit wrapping counter with async reset and increment enable. It is instantiated twice, for wptr and rptr.
- Flag and count logic stays in the top level.

Test Plan:
- Reset then idle: rst=1 for 5 cycles, release -> empty=1, full=0, count=0, waddr=raddr=0, overflow=underflow=0.
- Fill: wr_req=1 for 16 cycles, rd_req=0 -> waddr steps 0..15; threshold rises the cycle after the 12th write (count=12); full=1 after the 16th with count=16; wen drops to 0.
- Overflow: continue wr_req=1 at full for 3 cycles -> wen=0, pointers frozen, overflow=1 and held. Pulse err_clr with wr_req=0 -> overflow=0.
- Drain and underflow: rd_req=1 for 18 cycles -> rd_ack for 16 cycles, raddr 0..15; empty=1 after the 16th. The 17th request sets underflow=1; rptr stays at 16.
- Simultaneous and wrap: preload 5 entries, then wr_req=rd_req=1 for 40 cycles -> count stays 5. waddr and raddr wrap 15 -> 0 at least twice with no flag change. Repeat both at full and both at empty -> overflow and underflow respectively, with the other side accepted.
- Async reset mid-stream: with count=9, assert rst between clock edges -> count=0, empty=1 and wen=0 before the next wclk edge.
